// File: rtl/regfile_check_monitor_if.sv
// Bus bundle for regfile_check_monitor: table programming, run control, writeback snoop and status.
// master drives stimulus/configuration, slave is the monitor.
interface regfile_check_monitor_if #(
    parameter int XLEN       = 32,
    parameter int NUM_CHECKS = 8,
    parameter int MAX_CYCLES = 1024
);
    localparam int IW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam int MW = $clog2(NUM_CHECKS + 1);

    logic            cfg_we;
    logic [IW-1:0]   cfg_idx;
    logic            cfg_en;
    logic [4:0]      cfg_reg;
    logic [XLEN-1:0] cfg_val;
    logic            start;
    logic            halt;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            busy;
    logic            done;
    logic            pass;
    logic            timeout;
    logic [MW-1:0]   mismatch_cnt;
    logic [IW-1:0]   first_fail_idx;
    logic [XLEN-1:0] first_fail_val;
    logic [CW-1:0]   cycle_cnt;

    modport master (
        output cfg_we, cfg_idx, cfg_en, cfg_reg, cfg_val, start, halt, wb_en, wb_rd, wb_data,
        input  busy, done, pass, timeout, mismatch_cnt, first_fail_idx, first_fail_val, cycle_cnt
    );
    modport slave (
        input  cfg_we, cfg_idx, cfg_en, cfg_reg, cfg_val, start, halt, wb_en, wb_rd, wb_data,
        output busy, done, pass, timeout, mismatch_cnt, first_fail_idx, first_fail_val, cycle_cnt
    );
endinterface

// File: rtl/regfile_check_monitor.sv
// Shadows the register-file writeback port during a run, then walks a programmed
// (reg, value) table against the shadow and reports pass/fail, mismatches and cycle count.
module regfile_check_monitor #(
    parameter int XLEN       = 32,
    parameter int NUM_CHECKS = 8,
    parameter int MAX_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    regfile_check_monitor_if.slave bus
);
    localparam int IW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam int MW = $clog2(NUM_CHECKS + 1);

    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

    state_t          state;
    logic [XLEN-1:0] shadow  [32];
    logic            tbl_en  [NUM_CHECKS];
    logic [4:0]      tbl_reg [NUM_CHECKS];
    logic [XLEN-1:0] tbl_val [NUM_CHECKS];
    logic [IW-1:0]   chk_idx;
    logic [CW-1:0]   cycle_cnt;
    logic [MW-1:0]   mismatch_cnt;
    logic [IW-1:0]   first_fail_idx;
    logic [XLEN-1:0] first_fail_val;
    logic            pass;
    logic            timeout;

    logic [XLEN-1:0] chk_shadow;
    logic            entry_fail;
    logic [MW-1:0]   mismatch_next;
    logic            cfg_ok;

    // shadow[0] is never written, so checks against x0 naturally compare with 0
    always_comb begin
        chk_shadow    = shadow[tbl_reg[chk_idx]];
        entry_fail    = tbl_en[chk_idx] && (chk_shadow != tbl_val[chk_idx]);
        mismatch_next = mismatch_cnt + MW'(entry_fail);
        cfg_ok        = bus.cfg_we && (32'(bus.cfg_idx) < NUM_CHECKS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            chk_idx        <= '0;
            cycle_cnt      <= '0;
            mismatch_cnt   <= '0;
            first_fail_idx <= '0;
            first_fail_val <= '0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            for (int i = 0; i < 32; i++) shadow[i] <= '0;
            for (int i = 0; i < NUM_CHECKS; i++) begin
                tbl_en[i]  <= 1'b0;
                tbl_reg[i] <= '0;
                tbl_val[i] <= '0;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (cfg_ok) begin
                        tbl_en[bus.cfg_idx]  <= bus.cfg_en;
                        tbl_reg[bus.cfg_idx] <= bus.cfg_reg;
                        tbl_val[bus.cfg_idx] <= bus.cfg_val;
                    end
                    if (bus.start) begin
                        state          <= RUN;
                        chk_idx        <= '0;
                        cycle_cnt      <= '0;
                        mismatch_cnt   <= '0;
                        first_fail_idx <= '0;
                        first_fail_val <= '0;
                        pass           <= 1'b0;
                        timeout        <= 1'b0;
                        for (int i = 0; i < 32; i++) shadow[i] <= '0;
                    end
                end
                RUN: begin
                    cycle_cnt <= cycle_cnt + 1'b1;
                    if (bus.wb_en && bus.wb_rd != 5'd0) shadow[bus.wb_rd] <= bus.wb_data;
                    // halt wins over a coincident timeout
                    if (bus.halt) begin
                        state <= CHECK;
                    end else if (cycle_cnt == CW'(MAX_CYCLES - 1)) begin
                        timeout <= 1'b1;
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    mismatch_cnt <= mismatch_next;
                    if (entry_fail && mismatch_cnt == '0) begin
                        first_fail_idx <= chk_idx;
                        first_fail_val <= chk_shadow;
                    end
                    chk_idx <= chk_idx + 1'b1;
                    if (chk_idx == IW'(NUM_CHECKS - 1)) begin
                        state <= DONE;
                        pass  <= (mismatch_next == '0) && !timeout;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy           = (state == RUN) || (state == CHECK);
    assign bus.done           = (state == DONE);
    assign bus.pass           = pass;
    assign bus.timeout        = timeout;
    assign bus.mismatch_cnt   = mismatch_cnt;
    assign bus.first_fail_idx = first_fail_idx;
    assign bus.first_fail_val = first_fail_val;
    assign bus.cycle_cnt      = cycle_cnt;
endmodule

// File: tb/tb_regfile_check_monitor.sv
// Directed bench for regfile_check_monitor: a small behavioural model queues the expected
// report when a run ends, and the report is popped and compared once done rises.
module tb_regfile_check_monitor;
    localparam int NC = 8;
    localparam int MC = 16;

    typedef struct {
        logic        pass;
        logic        timeout;
        int          mism;
        int          ffi;
        logic [31:0] ffv;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_check_monitor_if #(.XLEN(32), .NUM_CHECKS(NC), .MAX_CYCLES(MC)) bus ();
    regfile_check_monitor #(.XLEN(32), .NUM_CHECKS(NC), .MAX_CYCLES(MC)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          runs = 0;
    exp_t        sb[$];
    bit          m_en  [NC];
    logic [4:0]  m_reg [NC];
    logic [31:0] m_val [NC];
    logic [31:0] m_sh  [32];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clear_model_table();
        for (int i = 0; i < NC; i++) begin
            m_en[i] = 1'b0; m_reg[i] = '0; m_val[i] = '0;
        end
    endtask

    // in_run: write is issued while a run is active, so it consumes a RUN cycle and is expected to be dropped
    task automatic cfg(input int idx, input bit en, input int r, input logic [31:0] v, input bit in_run);
        bus.cfg_we = 1'b1; bus.cfg_idx = 3'(idx); bus.cfg_en = en;
        bus.cfg_reg = 5'(r); bus.cfg_val = v;
        tick();
        bus.cfg_we = 1'b0;
        if (in_run) runs++;
        else begin
            m_en[idx] = en; m_reg[idx] = 5'(r); m_val[idx] = v;
        end
    endtask

    task automatic start_run();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        runs = 0;
        for (int i = 0; i < 32; i++) m_sh[i] = '0;
    endtask

    task automatic drive_wb(input int rd, input logic [31:0] d, input bit hlt);
        bus.wb_en = 1'b1; bus.wb_rd = 5'(rd); bus.wb_data = d; bus.halt = hlt;
        tick();
        bus.wb_en = 1'b0; bus.halt = 1'b0;
        runs++;
        if (rd != 0) m_sh[rd] = d;
    endtask

    task automatic idle_run(input int n);
        for (int i = 0; i < n; i++) tick();
        runs += n;
    endtask

    function automatic exp_t model_exp(input bit to);
        exp_t        e;
        logic [31:0] s;
        e.timeout = to; e.mism = 0; e.ffi = 0; e.ffv = '0; e.cyc = runs;
        for (int i = 0; i < NC; i++) begin
            if (m_en[i]) begin
                s = (m_reg[i] == 5'd0) ? 32'd0 : m_sh[m_reg[i]];
                if (s != m_val[i]) begin
                    if (e.mism == 0) begin e.ffi = i; e.ffv = s; end
                    e.mism++;
                end
            end
        end
        e.pass = (e.mism == 0) && !to;
        return e;
    endfunction

    task automatic wait_done(input string tag, input bit poke_start);
        int   lat = 0;
        exp_t e;
        chk({tag, "_busy"}, bus.busy, 1);
        if (poke_start) bus.start = 1'b1;
        while (!bus.done && lat < NC + 4) begin
            tick();
            bus.start = 1'b0;
            lat++;
        end
        chk({tag, "_latency"}, lat, NC);
        chk({tag, "_done"}, bus.done, 1);
        chk({tag, "_idle"}, bus.busy, 0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_pass"}, bus.pass, e.pass);
            chk({tag, "_timeout"}, bus.timeout, e.timeout);
            chk({tag, "_mism"}, bus.mismatch_cnt, e.mism);
            chk({tag, "_ffi"}, bus.first_fail_idx, e.ffi);
            chk({tag, "_ffv"}, bus.first_fail_val, e.ffv);
            chk({tag, "_cyc"}, bus.cycle_cnt, e.cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_pass"}, bus.pass, 0);
        chk({tag, "_timeout"}, bus.timeout, 0);
        chk({tag, "_mism"}, bus.mismatch_cnt, 0);
        chk({tag, "_ffi"}, bus.first_fail_idx, 0);
        chk({tag, "_ffv"}, bus.first_fail_val, 0);
        chk({tag, "_cyc"}, bus.cycle_cnt, 0);
    endtask

    task automatic program_basic();
        cfg(0, 1, 1, 32'd5, 0);
        cfg(1, 1, 2, 32'd3, 0);
        cfg(2, 1, 3, 32'd8, 0);
    endtask

    initial begin
        bus.cfg_we = 0; bus.cfg_idx = '0; bus.cfg_en = 0; bus.cfg_reg = '0; bus.cfg_val = '0;
        bus.start = 0; bus.halt = 0; bus.wb_en = 0; bus.wb_rd = '0; bus.wb_data = '0;
        clear_model_table();
        #3;
        check_all_zero("reset");
        tick();
        rst = 1'b0;
        tick();
        check_all_zero("post_reset");

        // 1: all match, halt with no writeback
        program_basic();
        start_run();
        drive_wb(1, 32'd5, 0); drive_wb(2, 32'd3, 0); drive_wb(3, 32'd8, 0);
        drive_wb(0, 32'd0, 1);
        sb.push_back(model_exp(0));
        wait_done("c1", 0);
        chk("c1_pass_const", bus.pass, 1);

        // 2: x3 wrong
        start_run();
        drive_wb(1, 32'd5, 0); drive_wb(2, 32'd3, 0); drive_wb(3, 32'd7, 0);
        drive_wb(0, 32'd0, 1);
        sb.push_back(model_exp(0));
        wait_done("c2", 0);
        chk("c2_ffi_const", bus.first_fail_idx, 2);
        chk("c2_ffv_const", bus.first_fail_val, 7);

        // 3: no halt -> timeout on the MC-th RUN cycle
        start_run();
        drive_wb(1, 32'd5, 0); drive_wb(2, 32'd3, 0); drive_wb(3, 32'd8, 0);
        idle_run(MC - 3);
        sb.push_back(model_exp(1));
        wait_done("c3", 0);
        chk("c3_cyc_const", bus.cycle_cnt, MC);

        // 4: halt on the MC-th cycle, x0 write dropped, halt-cycle writeback captured
        cfg(3, 1, 0, 32'd0, 0);
        cfg(4, 1, 4, 32'd1, 0);
        start_run();
        drive_wb(0, 32'd9, 0);
        drive_wb(1, 32'd5, 0); drive_wb(2, 32'd3, 0); drive_wb(3, 32'd8, 0);
        idle_run(MC - 5);
        drive_wb(4, 32'd1, 1);
        sb.push_back(model_exp(0));
        wait_done("c4", 0);
        chk("c4_timeout_const", bus.timeout, 0);

        // 5: disabled mismatching entry, cfg_we in RUN dropped, start in CHECK dropped
        cfg(5, 0, 1, 32'd1234, 0);
        start_run();
        cfg(0, 1, 1, 32'd99, 1);
        drive_wb(1, 32'd5, 0); drive_wb(2, 32'd3, 0); drive_wb(3, 32'd8, 0);
        drive_wb(4, 32'd1, 1);
        sb.push_back(model_exp(0));
        wait_done("c5", 1);

        // 6: reset mid-RUN aborts and clears the table (stale entry 4 would fail otherwise)
        start_run();
        drive_wb(1, 32'd5, 0);
        rst = 1'b1;
        #2;
        check_all_zero("c6_rst");
        tick();
        rst = 1'b0;
        clear_model_table();
        tick();
        check_all_zero("c6_idle");
        program_basic();
        start_run();
        drive_wb(1, 32'd5, 0); drive_wb(2, 32'd3, 0); drive_wb(3, 32'd8, 0);
        drive_wb(0, 32'd0, 1);
        sb.push_back(model_exp(0));
        wait_done("c6", 0);
        chk("c6_pass_const", bus.pass, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
